// File: rtl/nibble_seq_logic_8_pkg.sv
// Shared definitions for the time-multiplexed 8-bit logic unit:
// slice width, operation codes and FSM state encoding.
package nibble_seq_logic_8_pkg;

  localparam int W_NIB  = 4;
  localparam int W_WORD = 2 * W_NIB;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/nibble_seq_logic_8_if.sv
// Operand/result handshake bundle: upstream/downstream side is the master,
// the logic unit is the slave.
interface nibble_seq_logic_8_if;
  import nibble_seq_logic_8_pkg::*;

  logic [W_WORD-1:0] a;
  logic [W_WORD-1:0] b;
  logic [1:0]        op;
  logic              in_valid;
  logic              in_ready;
  logic [W_WORD-1:0] out;
  logic              zero;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output a, b, op, in_valid, out_ready,
    input  in_ready, out, zero, out_valid
  );

  modport slave (
    input  a, b, op, in_valid, out_ready,
    output in_ready, out, zero, out_valid
  );

endinterface

// File: rtl/nibble_seq_logic_8_logic_4.sv
// Combinational 4-bit slice applying the selected bitwise operation.
module logic_4
  import nibble_seq_logic_8_pkg::*;
(
  input  logic [W_NIB-1:0] i_a,
  input  logic [W_NIB-1:0] i_b,
  input  op_e              i_op,
  output logic [W_NIB-1:0] o_out
);

  always_comb begin
    o_out = '0;
    case (i_op)
      OP_AND:  o_out = i_a & i_b;
      OP_OR:   o_out = i_a | i_b;
      OP_XOR:  o_out = i_a ^ i_b;
      OP_NAND: o_out = ~(i_a & i_b);
      default: o_out = '0;
    endcase
  end

endmodule

// File: rtl/nibble_seq_logic_8.sv
// 8-bit bitwise logic unit built from one 4-bit slice used twice:
// low nibble in LO, high nibble in HI, result held in DONE until consumed.
module nibble_seq_logic_8
  import nibble_seq_logic_8_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  nibble_seq_logic_8_if.slave  bus
);

  state_e            r_state;
  logic [W_WORD-1:0] r_a;
  logic [W_WORD-1:0] r_b;
  op_e               r_op;
  logic [W_WORD-1:0] r_out;
  logic              r_zero;
  logic              r_out_valid;

  logic [W_NIB-1:0]  w_a_nib;
  logic [W_NIB-1:0]  w_b_nib;
  logic [W_NIB-1:0]  w_slice;

  // Only HI needs the upper nibble; every other state presents the lower one.
  assign w_a_nib = (r_state == HI) ? r_a[W_WORD-1:W_NIB] : r_a[W_NIB-1:0];
  assign w_b_nib = (r_state == HI) ? r_b[W_WORD-1:W_NIB] : r_b[W_NIB-1:0];

  logic_4 u_slice (
    .i_a   (w_a_nib),
    .i_b   (w_b_nib),
    .i_op  (r_op),
    .o_out (w_slice)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= OP_AND;
      r_out       <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_op    <= op_e'(bus.op);
            r_state <= LO;
          end
        end
        LO: begin
          r_out[W_NIB-1:0] <= w_slice;
          r_state          <= HI;
        end
        HI: begin
          r_out[W_WORD-1:W_NIB] <= w_slice;
          r_zero                <= ({w_slice, r_out[W_NIB-1:0]} == '0);
          r_out_valid           <= 1'b1;
          r_state               <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out       = r_out;
  assign bus.zero      = r_zero;
  assign bus.out_valid = r_out_valid;

endmodule

// File: doc/nibble_seq_logic_8.md
Name: nibble_seq_logic_8

Overview:
- Sequential 8-bit bitwise logic unit for the 8-bit ALU datapath.
- Uses one shared 4-bit logic slice to compute the low nibble, then the high nibble, over two clock cycles, and assembles the 8-bit result in a register.
- Operands are accepted and results are delivered over valid/ready handshakes.
- The existing 8-bit gates are spatial: two 4-bit instances side by side. This block does the same job time-multiplexed, with one 4-bit instance used twice.

Parameters:
- W_NIB, 4, slice width in bits; fixed, full word is 2*W_NIB = 8.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- a  input  8  operand A; sampled on acceptance.
- b  input  8  operand B; sampled on acceptance.
- op  input  2  operation; sampled on acceptance. 00=AND, 01=OR, 10=XOR, 11=NAND.
- in_valid  input  1  upstream has a, b, op valid.
- in_ready  output  1  block can accept; high only in IDLE.
- out  output  8  assembled result.
- zero  output  1  out == 8'h00; valid while out_valid.
- out_valid  output  1  result available.
- out_ready  input  1  downstream consumes the result.

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (rst). All state changes occur on the rising edge of clk.
- Reset, on the rising edge with rst=1, from any state including mid-operation:
  - state=IDLE, out=8'h00, zero=0, out_valid=0, and the operand registers clear to 0.
  - in_ready is 1 in the first cycle after reset.
  - Any in-flight operation is discarded, with no partial result visible.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 → capture a, b, op into registers; go to LO.
  - in_valid=0 → stay in IDLE.
- LO:
  - in_ready=0; the slice computes op(a_r[3:0], b_r[3:0]).
  - At the edge: out[3:0] ← slice result; go to HI.
  - out[7:4] keeps its previous value. Downstream must ignore out while out_valid=0.
- HI:
  - The slice computes op(a_r[7:4], b_r[7:4]).
  - At the edge: out[7:4] ← result; out_valid ← 1; zero ← (full new word == 0); go to DONE.
- DONE:
  - out_valid=1; out and zero are held stable.
  - out_ready=1 → out_valid ← 0; go to IDLE. out and zero keep their values (zero is don't-care once out_valid=0).
  - out_ready=0 → stay in DONE indefinitely (backpressure).
- Latency and throughput:
  - Acceptance edge is E0; out_valid is high after E2.
  - Minimum of 4 cycles per operation (IDLE, LO, HI, DONE); no overlap or pipelining.
- Handshake rules:
  - Input changes while in_ready=0 are ignored; captured operands are immune to upstream changes.
  - out_ready is ignored outside DONE.
  - in_valid asserted in DONE is not accepted until the block has returned to IDLE.
- NAND is computed per nibble as ~(x&y). No carries, so nibble order does not affect the result.
- out_valid, out and zero are all registered; there are no combinational paths from inputs to outputs. in_ready is decoded from state only.

Decomposition:
- Shared package: op encodings (OP_AND, OP_OR, OP_XOR, OP_NAND); FSM state encoding (IDLE=0, LO=1, HI=2, DONE=3); W_NIB.
- One sub-module, logic_4: combinational 4-bit op-selected slice (out, a, b, op), instanced once and fed through a nibble mux selected by state.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then release → out=8'h00, out_valid=0, in_ready=1. Holding in_valid=0 keeps the block in IDLE.
2. AND: a=8'hF0, b=8'h3C, op=00, out_ready=1 → out_valid high exactly 2 edges after acceptance, out=8'h30, zero=0; in_ready=1 again the following cycle.
3. All ops back-to-back on a=8'hA5, b=8'h0F → OR gives 8'hAF, XOR gives 8'hAA, NAND gives 8'hFA. Each takes 4 cycles. Operands changed during LO/HI do not alter the result.
4. Zero flag and backpressure: a=8'h55, b=8'hAA, op=AND, out_ready=0 for 5 cycles → out=8'h00, zero=1, out_valid held high with stable out; in_valid ignored. Raising out_ready → out_valid=0 and IDLE next cycle.
5. Reset mid-operation: accept op=XOR, assert rst during HI → next cycle out=8'h00, out_valid=0, in_ready=1; a new operation then completes correctly.
6. Random regression: 1000 random a, b, op with random out_ready stalls → every out matches a reference model, with exactly one result per accepted operand set.
